// File: rtl/cmult_pkg.sv
// Shared types and defaults for the complex-multiplier arbiter.
package cmult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int W_DEF       = 16;
    localparam int TIMEOUT_DEF = 64;
    localparam int NREQ_DEF    = 4;
    localparam int IDX_W_DEF   = $clog2(NREQ_DEF);

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cmult_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        int k;
        k   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            k = (int'(ptr) + i) % NREQ;
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/cmult_arbiter.sv
// Round-robin sharing of one multi-cycle complex multiplier among NREQ requesters,
// with a watchdog that aborts a hung multiplier transaction.
//
//   state | meaning
//   IDLE  | wait for m_ready and a request; grant and latch operands
//   ISSUE | m_enable high for this single cycle
//   ACK   | wait for multiplier to drop m_ready (accepted)
//   DONE  | wait for m_ready to return; capture and return the product
module cmult_arbiter
    import cmult_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [NREQ*W-1:0] req_a_r,
    input  logic [NREQ*W-1:0] req_a_i,
    input  logic [NREQ*W-1:0] req_b_r,
    input  logic [NREQ*W-1:0] req_b_i,
    output logic [NREQ-1:0] rsp_valid,
    output logic [W-1:0]    rsp_r,
    output logic [W-1:0]    rsp_i,
    output logic            rsp_err,
    output logic            err_sticky,
    output logic [W-1:0]    m_a_r,
    output logic [W-1:0]    m_a_i,
    output logic [W-1:0]    m_b_r,
    output logic [W-1:0]    m_b_i,
    output logic            m_enable,
    input  logic            m_ready,
    input  logic [W-1:0]    m_c_r,
    input  logic [W-1:0]    m_c_i
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    m_a_r_q, m_a_r_d, m_a_i_q, m_a_i_d;
    logic [W-1:0]    m_b_r_q, m_b_r_d, m_b_i_q, m_b_i_d;
    logic            m_enable_q, m_enable_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [W-1:0]    rsp_r_q, rsp_r_d, rsp_i_q, rsp_i_d;
    logic            rsp_err_q, rsp_err_d;
    logic            err_sticky_q, err_sticky_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            abort;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        m_a_r_d      = m_a_r_q;
        m_a_i_d      = m_a_i_q;
        m_b_r_d      = m_b_r_q;
        m_b_i_d      = m_b_i_q;
        m_enable_d   = 1'b0;
        rsp_valid_d  = '0;
        rsp_r_d      = rsp_r_q;
        rsp_i_d      = rsp_i_q;
        rsp_err_d    = 1'b0;
        err_sticky_d = err_sticky_q;
        req_ready    = '0;
        abort        = 1'b0;

        case (state_q)
            IDLE: begin
                // The m_ready gate also drains an op left in flight by a reset.
                if (m_ready && pick_any) begin
                    req_ready  = pick_gnt;
                    m_a_r_d    = req_a_r[int'(pick_idx)*W +: W];
                    m_a_i_d    = req_a_i[int'(pick_idx)*W +: W];
                    m_b_r_d    = req_b_r[int'(pick_idx)*W +: W];
                    m_b_i_d    = req_b_i[int'(pick_idx)*W +: W];
                    owner_d    = pick_idx;
                    m_enable_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = TO_LOAD;
                state_d = ACK;
            end
            ACK: begin
                if (!m_ready) begin
                    cnt_d   = TO_LOAD;
                    state_d = DONE;
                end else if (cnt_q == '0) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (m_ready) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_r_d = m_c_r;
                    rsp_i_d = m_c_i;
                    ptr_d   = IW'(wrap_inc(int'(owner_q), NREQ));
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            rsp_valid_d[owner_q] = 1'b1;
            rsp_err_d    = 1'b1;
            rsp_r_d      = '0;
            rsp_i_d      = '0;
            err_sticky_d = 1'b1;
            ptr_d        = IW'(wrap_inc(int'(owner_q), NREQ));
            state_d      = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            cnt_q        <= '0;
            m_a_r_q      <= '0;
            m_a_i_q      <= '0;
            m_b_r_q      <= '0;
            m_b_i_q      <= '0;
            m_enable_q   <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_r_q      <= '0;
            rsp_i_q      <= '0;
            rsp_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            m_a_r_q      <= m_a_r_d;
            m_a_i_q      <= m_a_i_d;
            m_b_r_q      <= m_b_r_d;
            m_b_i_q      <= m_b_i_d;
            m_enable_q   <= m_enable_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_r_q      <= rsp_r_d;
            rsp_i_q      <= rsp_i_d;
            rsp_err_q    <= rsp_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign m_a_r      = m_a_r_q;
    assign m_a_i      = m_a_i_q;
    assign m_b_r      = m_b_r_q;
    assign m_b_i      = m_b_i_q;
    assign m_enable   = m_enable_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_r      = rsp_r_q;
    assign rsp_i      = rsp_i_q;
    assign rsp_err    = rsp_err_q;
    assign err_sticky = err_sticky_q;

endmodule
